// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        rd_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall_req
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  op_r;      // op[1]=1 selects divide
  logic [31:0] a_reg;     // multiplicand / dividend magnitude (dividend shifts left)
  logic [31:0] b_reg;     // multiplier magnitude (shifts right) / divisor magnitude
  logic [31:0] rs_raw;    // original dividend, returned in HI on divide by zero
  logic        neg_res;   // product or quotient must be negated
  logic        neg_rem;   // remainder takes the dividend's sign
  logic [63:0] acc;       // mul: running product; div: {remainder, quotient}
  logic [5:0]  cnt;

  // operand conditioning for a newly issued operation
  logic        is_signed;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;

  // one iteration step and final sign fix
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [32:0] div_diff;
  logic [63:0] acc_next;
  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  // magnitudes and sign flags for the operands on the buses this cycle
  always_comb begin
    is_signed = ~op[0];
    rs_mag    = (is_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    rt_mag    = (is_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
  end

  // next accumulator value for one shift-add or restoring-divide step
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (b_reg[0] ? a_reg : 32'd0)};
    div_trial = {acc[63:32], a_reg[31]};
    div_diff  = div_trial - {1'b0, b_reg};
    acc_next  = acc;
    if (!op_r[1]) begin
      acc_next = {mul_sum, acc[31:1]};
    end else if (!div_diff[32]) begin
      acc_next = {div_diff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_next = {div_trial[31:0], acc[30:0], 1'b0};
    end
  end

  // signed results recovered from the magnitude-path accumulator
  always_comb begin
    prod_fixed = neg_res ? (64'd0 - acc) : acc;
    quo_fixed  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fixed  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
  end

  // control FSM, iteration datapath and architectural HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_r    <= 2'd0;
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      rs_raw  <= 32'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= 64'd0;
      cnt     <= 6'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // a start in the same cycle as mthi/mtlo wins; the writes are dropped
            op_r    <= op;
            a_reg   <= rs_mag;
            b_reg   <= rt_mag;
            rs_raw  <= rs_data;
            neg_res <= is_signed & (rs_data[31] ^ rt_data[31]);
            neg_rem <= is_signed & rs_data[31];
            acc     <= 64'd0;
            cnt     <= 6'd0;
            state   <= CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (op_r[1]) begin
            a_reg <= {a_reg[30:0], 1'b0};
          end else begin
            b_reg <= {1'b0, b_reg[31:1]};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          if (!op_r[1]) begin
            hi <= prod_fixed[63:32];
            lo <= prod_fixed[31:0];
          end else if (b_reg == 32'd0) begin
            // divide by zero: magnitude path would give garbage, report fixed pattern
            hi <= rs_raw;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= rem_fixed;
            lo <= quo_fixed;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // status decode and hold request while an operation is in flight
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    stall_req = ((state == CALC) || (state == FIX)) && (start || rd_req || hi_we || lo_we);
  end

endmodule
